segment_scan: RTL and testbench
===============================

SEGMENT_SCAN -- requirements
Module: segment_scan

Interface
REQ-001 SHALL have the parameter DIGITS, default 4 (legal range 2..8), giving the number of multiplexed digits.
REQ-002 SHALL have the parameter ON_CYCLES, default 10000 (minimum 1), giving the clocks each digit is driven.
REQ-003 SHALL have the parameter DEAD_CYCLES, default 100 (minimum 0), giving the all-off clocks after each digit.
REQ-004 SHALL have the parameter SEG_ACTIVE_LOW, default 0; when 1, seg_out is inverted.
REQ-005 SHALL have the parameter DIG_ACTIVE_LOW, default 0; when 1, dig_sel is inverted.
REQ-006 SHALL have the port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-007 SHALL have the port rst, input, 1 bit: asynchronous active-high reset.
REQ-008 SHALL have the port load, input, 1 bit: a one-cycle strobe that captures data, dp and blank.
REQ-009 SHALL have the port data, input, 4*DIGITS bits: hex nibbles, where nibble i is digit i and digit 0 is the rightmost digit.
REQ-010 SHALL have the port dp, input, DIGITS bits: the per-digit decimal-point enable.
REQ-011 SHALL have the port blank, input, DIGITS bits: the per-digit forced blank.
REQ-012 SHALL have the port lz_en, input, 1 bit: leading-zero suppression enable, sampled live each cycle.
REQ-013 SHALL have the port seg_out, output, 8 bits: DP,G,F,E,D,C,B,A from MSB to LSB, with segments active-high before polarity.
REQ-014 SHALL have the port dig_sel, output, DIGITS bits: a one-hot digit enable.
REQ-015 SHALL have the port ack, output, 1 bit: a one-cycle pulse when a pending load becomes displayed.
REQ-016 SHALL have the port frame_done, output, 1 bit: a one-cycle pulse at the end of each full scan.

Function
REQ-017 SHALL decode hex to segments as 0=3f, 1=06, 2=5b, 3=4f, 4=66, 5=6d, 6=7d, 7=07, 8=7f, 9=6f, A=77, b=7c, C=39, d=5e, E=79, F=71 (bits G..A).
REQ-018 SHALL hold two buffers of {data, dp, blank}: pending and active, with a pending_valid flag.
REQ-019 SHALL, on load=1, capture the inputs into pending and set pending_valid; a later load before the frame boundary overwrites pending.
REQ-020 SHALL run a scan FSM with states ON and DEAD, a digit index idx (0..DIGITS-1) and a cycle counter.
REQ-021 SHALL, in ON, assert dig_sel bit idx and drive that digit's pattern for exactly ON_CYCLES clocks, then go to DEAD.
REQ-022 SHALL, in DEAD, drive dig_sel all-off and seg_out all-off for DEAD_CYCLES clocks; if DEAD_CYCLES=0, go directly ON to ON with the next idx.
REQ-023 SHALL, at the end of digit idx, advance idx by 1 and wrap from DIGITS-1 to 0; the wrap cycle is the frame boundary.
REQ-024 SHALL, at the frame boundary with pending_valid=1, copy pending to active, clear pending_valid, and pulse ack on the next cycle.
REQ-025 SHALL, when load coincides with the frame boundary, apply the old pending to active and store the new capture as pending with pending_valid left set.
REQ-026 SHALL pulse frame_done for one cycle on the same cycle that the ack for that boundary would appear.
REQ-027 SHALL blank a digit (segments A..G all 0) if its active blank bit is 1.
REQ-028 SHALL, when lz_en=1, also blank a digit if it and every higher digit hold nibble 0 and are not forced-blank.
REQ-029 SHALL never suppress digit 0 through leading-zero suppression.
REQ-030 SHALL drive the DP segment from active dp[idx] unless blank[idx]=1; leading-zero suppression does not clear DP.
REQ-031 SHALL register seg_out and dig_sel, with one-cycle latency from the FSM state, and shall never drive two digit enables simultaneously.
REQ-032 SHALL apply the polarity parameters only at the output registers.

Reset
REQ-033 SHALL, on rst=1, immediately force seg_out and dig_sel to their inactive level and set ack=0, frame_done=0 and pending_valid=0.
REQ-034 SHALL, on rst=1, reset active data and dp to 0, active blank to all ones, idx to 0, the state to ON and the counter to 0.
REQ-035 SHALL, when reset is asserted mid-scan or with a load pending, discard all state; the first load after release is displayed at the first frame boundary.

Verification (DIGITS=4, ON_CYCLES=4, DEAD_CYCLES=2, polarity 0)
REQ-036 SHALL cover this case: reset release with no load -> dig_sel cycles 0001, 0010, 0100, 1000 at 4 on and 2 off each, seg_out=00 throughout, and frame_done every 24 clocks.
REQ-037 SHALL cover this case: load data=16'h12AF, dp=0, blank=0 -> ack at the next boundary, then digit 0 = 71, 1 = 77, 2 = 5b, 3 = 06.
REQ-038 SHALL cover this case: data=16'h0050, lz_en=1 -> digits 3 and 2 read 00, digit 1 reads 6d and digit 0 reads 3f; with dp=4'b1000, digit 3 reads 80.
REQ-039 SHALL cover this case: two loads within one frame (0x1111, then 0x2222) -> exactly one ack, and 0x2222 is displayed.
REQ-040 SHALL cover this case: load on the boundary cycle -> the previous pending is displayed with ack, the new value is displayed at the following boundary, and a second ack follows.
REQ-041 SHALL cover this case: rst asserted during ON of digit 2 -> outputs go inactive in the same cycle, and after release the scan restarts at digit 0 blank.

Source files
------------

// File: rtl/segment_scan.sv
// segment_scan: multiplexed 7-segment driver with a double-buffered frame,
// leading-zero suppression and dead time between digits.
// Load handshake: load is a one-cycle strobe with no back-pressure.
// A captured value waits in the pending buffer until the next frame boundary.
// ack pulses on the cycle after that value moves into the active buffer.
module segment_scan #(
  parameter int DIGITS         = 4,
  parameter int ON_CYCLES      = 10000,
  parameter int DEAD_CYCLES    = 100,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_en,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  ack,
  output logic                  frame_done
);

  localparam int CNT_MAX   = (ON_CYCLES > DEAD_CYCLES) ? ON_CYCLES : DEAD_CYCLES;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int IW        = $clog2(DIGITS);
  localparam int DEAD_LAST = (DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0;
  localparam logic [7:0]        SEG_INV = SEG_ACTIVE_LOW ? 8'hff : 8'h00;
  localparam logic [DIGITS-1:0] DIG_INV = DIG_ACTIVE_LOW ? '1 : '0;

  typedef enum logic {ST_ON = 1'b0, ST_DEAD = 1'b1} state_t;

  state_t            state, state_n;
  logic [IW-1:0]     idx, idx_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              end_digit;
  logic              boundary;

  logic [4*DIGITS-1:0] pend_data, act_data;
  logic [DIGITS-1:0]   pend_dp, act_dp;
  logic [DIGITS-1:0]   pend_blank, act_blank;
  logic                pend_valid;

  logic [DIGITS-1:0]   lz;
  logic                zero_run;
  logic [3:0]          nib;
  logic                hide;
  logic [7:0]          seg_pat;
  logic [DIGITS-1:0]   dig_pat;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3f;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5b;
      4'h3: hex7 = 7'h4f;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6d;
      4'h6: hex7 = 7'h7d;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7f;
      4'h9: hex7 = 7'h6f;
      4'ha: hex7 = 7'h77;
      4'hb: hex7 = 7'h7c;
      4'hc: hex7 = 7'h39;
      4'hd: hex7 = 7'h5e;
      4'he: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Scan FSM state register: current phase, digit index and cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_ON;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
    end
  end

  // Scan FSM next state; a digit ends after its dead time (or after ON when there is none).
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt + 1'b1;
    end_digit = 1'b0;
    case (state)
      ST_ON: begin
        if (cnt == CW'(ON_CYCLES - 1)) begin
          cnt_n = '0;
          if (DEAD_CYCLES == 0) end_digit = 1'b1;
          else                  state_n   = ST_DEAD;
        end
      end
      default: begin
        if (cnt == CW'(DEAD_LAST)) begin
          cnt_n     = '0;
          end_digit = 1'b1;
          state_n   = ST_ON;
        end
      end
    endcase
    if (end_digit) idx_n = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    boundary = end_digit && (idx == IW'(DIGITS - 1));
  end

  // Frame buffers: a load on the boundary cycle still lands in pending after the swap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_valid <= 1'b0;
      act_data   <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
      ack        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (boundary && pend_valid) begin
        act_data  <= pend_data;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
      end
      if (load) begin
        pend_data  <= data;
        pend_dp    <= dp;
        pend_blank <= blank;
        pend_valid <= 1'b1;
      end else if (boundary) begin
        pend_valid <= 1'b0;
      end
      ack        <= boundary && pend_valid;
      frame_done <= boundary;
    end
  end

  // Segment pattern for the current digit, including leading-zero suppression.
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (act_data[i*4 +: 4] == 4'h0) && !act_blank[i];
      lz[i]    = zero_run && (i != 0);
    end
    nib     = act_data[idx*4 +: 4];
    hide    = act_blank[idx] | (lz_en & lz[idx]);
    seg_pat = {act_dp[idx] & ~act_blank[idx], hide ? 7'h00 : hex7(nib)};
    dig_pat = '0;
    dig_pat[idx] = 1'b1;
    if (state == ST_DEAD) begin
      seg_pat = 8'h00;
      dig_pat = '0;
    end
  end

  // Output registers; polarity is applied only here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_out <= SEG_INV;
      dig_sel <= DIG_INV;
    end else begin
      seg_out <= seg_pat ^ SEG_INV;
      dig_sel <= dig_pat ^ DIG_INV;
    end
  end

endmodule

// File: tb/tb_segment_scan.sv
// tb_segment_scan: table-driven frames plus hand-written boundary, double-load
// and mid-scan reset sequences for segment_scan (4 digits, 4 on, 2 dead).
module tb_segment_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lz_en;
  logic [7:0]  seg_out;
  logic [3:0]  dig_sel;
  logic        ack;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz;
    logic [31:0] exp;  // {digit3, digit2, digit1, digit0} segment bytes
  } vec_t;

  vec_t vecs[8];

  segment_scan #(
    .DIGITS(4), .ON_CYCLES(4), .DEAD_CYCLES(2),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .data(data), .dp(dp), .blank(blank),
    .lz_en(lz_en), .seg_out(seg_out), .dig_sel(dig_sel), .ack(ack),
    .frame_done(frame_done)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Drive a load strobe for exactly one rising edge, starting at the current negedge.
  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    data  = d;
    dp    = p;
    blank = b;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    while (ack !== 1'b1 && n < 80) begin
      tick();
      n++;
    end
    check({name, "_ack_seen"}, 32'(ack), 32'd1);
    check({name, "_ack_with_frame_done"}, 32'(frame_done), 32'd1);
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    tick();
    while (frame_done !== 1'b1 && n < 80) begin
      tick();
      n++;
    end
    check({name, "_frame_seen"}, 32'(frame_done), 32'd1);
  endtask

  // Observe one full frame starting at the cycle after a boundary pulse and
  // compare it with the next expected frame in the scoreboard.
  task automatic capture_check(input string name, input int exp_acks);
    logic [31:0] segs = '0;
    logic [3:0]  exp_dig;
    logic [31:0] exp;
    int seq_err = 0;
    int fd_cnt  = 0;
    int ack_cnt = 0;
    for (int c = 0; c < 24; c++) begin
      int d, p;
      tick();
      d = c / 6;
      p = c % 6;
      exp_dig = (p < 4) ? (4'b0001 << d) : 4'b0000;
      if (dig_sel !== exp_dig) seq_err++;
      if (p >= 4 && seg_out !== 8'h00) seq_err++;
      if (p == 0) segs[d*8 +: 8] = seg_out;
      else if (p < 4 && seg_out !== segs[d*8 +: 8]) seq_err++;
      if (frame_done === 1'b1) begin
        fd_cnt++;
        if (c != 23) seq_err++;
      end
      if (ack === 1'b1) ack_cnt++;
    end
    check({name, "_scan_seq_errors"}, 32'(seq_err), 32'd0);
    check({name, "_frame_done_count"}, 32'(fd_cnt), 32'd1);
    check({name, "_ack_count"}, 32'(ack_cnt), 32'(exp_acks));
    if (exp_q.size() == 0) begin
      check({name, "_scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check({name, "_segments"}, segs, exp);
    end
  endtask

  initial begin
    // stimulus table
    vecs[0] = '{16'h12AF, 4'b0000, 4'b0000, 1'b0, 32'h065b7771};
    vecs[1] = '{16'h0050, 4'b0000, 4'b0000, 1'b1, 32'h00006d3f};
    vecs[2] = '{16'h0050, 4'b1000, 4'b0000, 1'b1, 32'h80006d3f};
    vecs[3] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 32'h0000003f};
    vecs[4] = '{16'h89CD, 4'b0011, 4'b0100, 1'b0, 32'h7f00b9de};
    vecs[5] = '{16'h0030, 4'b1000, 4'b1000, 1'b1, 32'h003f4f3f};
    vecs[6] = '{16'h0000, 4'b0101, 4'b0000, 1'b0, 32'h3fbf3fbf};
    vecs[7] = '{16'h0007, 4'b0010, 4'b0000, 1'b1, 32'h00008007};

    // reset
    rst = 1'b1; load = 1'b0; data = '0; dp = '0; blank = '0; lz_en = 1'b0;
    repeat (3) tick();
    check("reset_seg_out", 32'(seg_out), 32'h0);
    check("reset_dig_sel", 32'(dig_sel), 32'h0);
    check("reset_ack", 32'(ack), 32'h0);
    check("reset_frame_done", 32'(frame_done), 32'h0);
    rst = 1'b0;

    // no load: blank frames, frame_done every 24 clocks
    exp_q.push_back(32'h0);
    capture_check("idle_frame0", 0);
    exp_q.push_back(32'h0);
    capture_check("idle_frame1", 0);

    // table-driven frames
    for (int i = 0; i < 8; i++) begin
      lz_en = vecs[i].lz;
      do_load(vecs[i].data, vecs[i].dp, vecs[i].blank);
      exp_q.push_back(vecs[i].exp);
      wait_ack($sformatf("vec%0d", i));
      capture_check($sformatf("vec%0d", i), 0);
    end

    // two loads within one frame: only the second is shown, one ack
    lz_en = 1'b0;
    wait_frame("dbl");
    do_load(16'h1111, 4'b0000, 4'b0000);
    repeat ($urandom_range(1, 8)) tick();
    do_load(16'h2222, 4'b0000, 4'b0000);
    exp_q.push_back(32'h5b5b5b5b);
    wait_ack("dbl");
    capture_check("dbl_first", 0);
    exp_q.push_back(32'h5b5b5b5b);
    capture_check("dbl_second", 0);

    // load coinciding with the frame boundary
    wait_frame("bnd");                   // negedge F
    do_load(16'h3333, 4'b0000, 4'b0000); // now F+1, pending = 3333
    repeat (22) tick();                  // F+23, next edge is the boundary
    do_load(16'h4444, 4'b0000, 4'b0000); // now F+24
    check("bnd_ack", 32'(ack), 32'd1);
    check("bnd_frame_done", 32'(frame_done), 32'd1);
    exp_q.push_back(32'h4f4f4f4f);
    capture_check("bnd_old", 1);         // second ack closes this frame
    exp_q.push_back(32'h66666666);
    capture_check("bnd_new", 0);

    // reset during ON of digit 2 with a load pending
    wait_frame("rst");                   // negedge F, active shows 4444
    do_load(16'h8888, 4'b0000, 4'b0000);
    repeat (13) tick();                  // F+14: digit 2 on
    check("rst_pre_dig_sel", 32'(dig_sel), 32'h4);
    check("rst_pre_seg_out", 32'(seg_out), 32'h66);
    rst = 1'b1;
    #1;
    check("rst_mid_dig_sel", 32'(dig_sel), 32'h0);
    check("rst_mid_seg_out", 32'(seg_out), 32'h0);
    check("rst_mid_ack", 32'(ack), 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    exp_q.push_back(32'h0);
    capture_check("rst_after", 0);
    do_load(16'h4321, 4'b0000, 4'b0000);
    exp_q.push_back(32'h664f5b06);
    wait_ack("rst_load");
    capture_check("rst_load", 0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
